// File: rtl/trap_controller.sv
// trap_controller: arbitrates F/E exception codes, latches mepc/mcause/mtval,
// redirects the PC to the trap vector with an F/D/E flush, tracks the privilege
// region (reset handler / user text / trap handler) and handles mret returns.
// Build option: define TRAP_COUNTER_EN to add a saturating trap counter read at
// CSR index 3; without it index 3 reads as zero.

`ifndef NO_E
`define NO_E 4'hF
`endif

module trap_controller #(
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0000,
    parameter logic [31:0] RESET_VEC = 32'h0004_0000,
    parameter logic [31:0] TEXT_BASE = 32'h0008_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_exception_code_f,
    input  logic [3:0]  i_exception_code_e,
    input  logic [31:0] i_pc_f,
    input  logic [31:0] i_pc_e,
    input  logic [31:0] i_alu_out_e,
    input  logic        i_mret_e,
    input  logic        i_csr_we,
    input  logic [1:0]  i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata,
    output logic        o_redirect,
    output logic [31:0] o_redirect_addr,
    output logic        o_flush_fde,
    output logic        o_reset_permission,
    output logic        o_trap_permission,
    output logic        o_halt
);

    // RESET_VEC only documents where the pipeline boots; nothing here consumes it.
    localparam logic [31:0] BOOT_VEC_UNUSED = RESET_VEC;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_RUN    = 3'd1,
        ST_ENTER  = 3'd2,
        ST_TRAP   = 3'd3,
        ST_RETURN = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_addr_q, redirect_addr_d;
    logic        flush_q, flush_d;
    logic        reset_perm_q, reset_perm_d;
    logic        trap_perm_q, trap_perm_d;
    logic        halt_q, halt_d;

    logic exc_e;
    logic exc_f;
    logic priv_fault;

    assign exc_e = (i_exception_code_e != `NO_E);
    assign exc_f = (i_exception_code_f != `NO_E);
    // In a privileged region any fault is fatal; an F fault loses only to an mret in E.
    assign priv_fault = exc_e || (exc_f && !i_mret_e);

    // Next-state, CSR update and registered-output computation.
    always_comb begin
        state_d         = state_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        redirect_addr_d = TRAP_VEC;
        case (state_q)
            ST_RESET: begin
                if (priv_fault) begin
                    state_d = ST_HALT;
                end else if (i_mret_e) begin
                    state_d         = ST_RETURN;
                    redirect_addr_d = TEXT_BASE;
                end
            end
            ST_RUN: begin
                // E is older than F, so it wins; mret in E suppresses a younger F fault.
                if (exc_e) begin
                    state_d  = ST_ENTER;
                    mepc_d   = i_pc_e;
                    mcause_d = {28'b0, i_exception_code_e};
                    mtval_d  = i_alu_out_e;
                end else if (exc_f && !i_mret_e) begin
                    state_d  = ST_ENTER;
                    mepc_d   = i_pc_f;
                    mcause_d = {28'b0, i_exception_code_f};
                    mtval_d  = i_pc_f;
                end
                redirect_addr_d = TRAP_VEC;
            end
            ST_ENTER: begin
                // Everything in flight is wrong-path and gets flushed.
                state_d = ST_TRAP;
            end
            ST_TRAP: begin
                if (priv_fault) begin
                    state_d = ST_HALT;
                end else begin
                    if (i_csr_we) begin
                        case (i_csr_addr)
                            2'd0:    mepc_d   = i_csr_wdata;
                            2'd1:    mcause_d = i_csr_wdata;
                            2'd2:    mtval_d  = i_csr_wdata;
                            default: ;
                        endcase
                    end
                    if (i_mret_e) begin
                        state_d         = ST_RETURN;
                        redirect_addr_d = mepc_d;
                    end
                end
            end
            ST_RETURN: state_d = ST_RUN;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase

        redirect_d   = (state_d == ST_ENTER) || (state_d == ST_RETURN);
        flush_d      = redirect_d;
        reset_perm_d = (state_d == ST_RESET);
        trap_perm_d  = (state_d == ST_TRAP);
        halt_d       = (state_d == ST_HALT);
    end

    // State, CSRs and all outputs except the CSR read port are registered here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= ST_RESET;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
            flush_q         <= 1'b0;
            reset_perm_q    <= 1'b1;
            trap_perm_q     <= 1'b0;
            halt_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            redirect_q      <= redirect_d;
            redirect_addr_q <= redirect_addr_d;
            flush_q         <= flush_d;
            reset_perm_q    <= reset_perm_d;
            trap_perm_q     <= trap_perm_d;
            halt_q          <= halt_d;
        end
    end

    logic [31:0] idx3_rdata;

`ifdef TRAP_COUNTER_EN
    logic [31:0] trap_count_q, trap_count_d;

    // Count each entry into the trap handler, sticking at all-ones.
    always_comb begin
        trap_count_d = trap_count_q;
        if ((state_q == ST_RUN) && (state_d == ST_ENTER) && (trap_count_q != 32'hFFFF_FFFF))
            trap_count_d = trap_count_q + 32'd1;
    end

    // Trap counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) trap_count_q <= '0;
        else       trap_count_q <= trap_count_d;
    end

    assign idx3_rdata = trap_count_q;
`else
    assign idx3_rdata = 32'h0;
`endif

    // Combinational CSR read port.
    always_comb begin
        o_csr_rdata = 32'h0;
        case (i_csr_addr)
            2'd0:    o_csr_rdata = mepc_q;
            2'd1:    o_csr_rdata = mcause_q;
            2'd2:    o_csr_rdata = mtval_q;
            default: o_csr_rdata = idx3_rdata | (BOOT_VEC_UNUSED & 32'h0);
        endcase
    end

    assign o_redirect         = redirect_q;
    assign o_redirect_addr    = redirect_addr_q;
    assign o_flush_fde        = flush_q;
    assign o_reset_permission = reset_perm_q;
    assign o_trap_permission  = trap_perm_q;
    assign o_halt             = halt_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller: boot mret, E-over-F trap,
// handler mepc rewrite and return, F-stage trap, double fault halt, reset recovery.
`timescale 1ns/1ps

`ifndef NO_E
`define NO_E 4'hF
`endif
`ifndef E_ILLEGAL_INSTR
`define E_ILLEGAL_INSTR 4'd2
`endif
`ifndef E_LOAD_ADDR_MISALIGNED
`define E_LOAD_ADDR_MISALIGNED 4'd4
`endif
`ifndef E_STORE_ADDR_MISALIGNED
`define E_STORE_ADDR_MISALIGNED 4'd6
`endif
`ifndef E_SP_OUT_OF_RANGE
`define E_SP_OUT_OF_RANGE 4'd12
`endif

module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  code_f, code_e;
    logic [31:0] pc_f, pc_e, alu;
    logic        mret, csr_we;
    logic [1:0]  csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        redirect, flush, reset_perm, trap_perm, halt;
    logic [31:0] redirect_addr;

    int n_cmp = 0;
    int n_bad = 0;

    trap_controller dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_exception_code_f (code_f),
        .i_exception_code_e (code_e),
        .i_pc_f             (pc_f),
        .i_pc_e             (pc_e),
        .i_alu_out_e        (alu),
        .i_mret_e           (mret),
        .i_csr_we           (csr_we),
        .i_csr_addr         (csr_addr),
        .i_csr_wdata        (csr_wdata),
        .o_csr_rdata        (csr_rdata),
        .o_redirect         (redirect),
        .o_redirect_addr    (redirect_addr),
        .o_flush_fde        (flush),
        .o_reset_permission (reset_perm),
        .o_trap_permission  (trap_perm),
        .o_halt             (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("check %-16s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_csr(input logic [1:0] a, input string tag, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    logic [31:0] cnt_exp3;

    initial begin
`ifdef TRAP_COUNTER_EN
        cnt_exp3 = 32'd3;
`else
        cnt_exp3 = 32'd0;
`endif
        rst = 1'b1; code_f = `NO_E; code_e = `NO_E; pc_f = '0; pc_e = '0; alu = '0;
        mret = 1'b0; csr_we = 1'b0; csr_addr = 2'd0; csr_wdata = '0;
        repeat (3) step();
        check("rst_reset_perm", {31'b0, reset_perm}, 32'd1);
        check("rst_trap_perm",  {31'b0, trap_perm},  32'd0);
        check("rst_redirect",   {31'b0, redirect},   32'd0);
        check("rst_flush",      {31'b0, flush},      32'd0);
        check("rst_halt",       {31'b0, halt},       32'd0);
        for (int a = 0; a < 4; a++) read_csr(a[1:0], "rst_csr", 32'h0);
        rst = 1'b0;

        // Boot handler issues mret: one-cycle redirect to user text.
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("boot_redirect",  {31'b0, redirect}, 32'd1);
        check("boot_addr",      redirect_addr,     32'h0008_0000);
        check("boot_flush",     {31'b0, flush},    32'd1);
        step();
        check("run_redirect",   {31'b0, redirect},   32'd0);
        check("run_reset_perm", {31'b0, reset_perm}, 32'd0);
        check("run_trap_perm",  {31'b0, trap_perm},  32'd0);

        // mret in ST_RUN is ignored.
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("run_mret_ign", {31'b0, redirect}, 32'd0);

        // CSR write outside trap handler is ignored.
        csr_we = 1'b1; csr_addr = 2'd1; csr_wdata = 32'hDEAD_BEEF;
        step();
        csr_we = 1'b0;
        read_csr(2'd1, "run_csr_wr_ign", 32'h0);

        // E and F fault together: E wins.
        code_e = `E_LOAD_ADDR_MISALIGNED; pc_e = 32'h0008_0010; alu = 32'h0010_0002;
        code_f = `E_ILLEGAL_INSTR; pc_f = 32'h0008_0018;
        step();
        code_e = `NO_E; code_f = `NO_E;
        check("t1_redirect", {31'b0, redirect}, 32'd1);
        check("t1_addr",     redirect_addr,     32'h0000_0000);
        check("t1_flush",    {31'b0, flush},    32'd1);
        read_csr(2'd0, "t1_mepc",   32'h0008_0010);
        read_csr(2'd1, "t1_mcause", {28'b0, `E_LOAD_ADDR_MISALIGNED});
        read_csr(2'd2, "t1_mtval",  32'h0010_0002);
        step();
        check("t1_trap_perm",  {31'b0, trap_perm}, 32'd1);
        check("t1_redir_done", {31'b0, redirect},  32'd0);

        // Handler advances mepc, then returns.
        csr_we = 1'b1; csr_addr = 2'd0; csr_wdata = 32'h0008_0014;
        step();
        csr_we = 1'b0;
        read_csr(2'd0, "h_mepc_wr", 32'h0008_0014);
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("ret_redirect",  {31'b0, redirect},  32'd1);
        check("ret_addr",      redirect_addr,      32'h0008_0014);
        check("ret_flush",     {31'b0, flush},     32'd1);
        check("ret_trap_perm", {31'b0, trap_perm}, 32'd0);
        step();
        check("ret_done", {31'b0, redirect}, 32'd0);

        // F-stage fault alone: mepc and mtval take the fetch PC.
        code_f = `E_ILLEGAL_INSTR; pc_f = 32'h0008_0020;
        step();
        code_f = `NO_E;
        check("t2_redirect", {31'b0, redirect}, 32'd1);
        read_csr(2'd0, "t2_mepc",   32'h0008_0020);
        read_csr(2'd1, "t2_mcause", {28'b0, `E_ILLEGAL_INSTR});
        read_csr(2'd2, "t2_mtval",  32'h0008_0020);
        step();
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("t2_ret_addr", redirect_addr, 32'h0008_0020);
        step();

        // Third trap, then a fault inside the handler: double fault halt.
        code_e = `E_STORE_ADDR_MISALIGNED; pc_e = 32'h0008_0030; alu = 32'h0020_0001;
        step();
        code_e = `NO_E;
        step();
        check("t3_trap_perm", {31'b0, trap_perm}, 32'd1);
        code_e = `E_SP_OUT_OF_RANGE; pc_e = 32'h0000_0040; alu = 32'h1234_5678;
        csr_we = 1'b1; csr_addr = 2'd1; csr_wdata = 32'hAAAA_5555;
        step();
        code_e = `NO_E; csr_we = 1'b0;
        check("df_halt",      {31'b0, halt},      32'd1);
        check("df_redirect",  {31'b0, redirect},  32'd0);
        check("df_flush",     {31'b0, flush},     32'd0);
        check("df_trap_perm", {31'b0, trap_perm}, 32'd0);
        read_csr(2'd0, "df_mepc",   32'h0008_0030);
        read_csr(2'd1, "df_mcause", {28'b0, `E_STORE_ADDR_MISALIGNED});
        read_csr(2'd2, "df_mtval",  32'h0020_0001);
        read_csr(2'd3, "trap_count", cnt_exp3);
        mret = 1'b1;
        repeat (3) step();
        mret = 1'b0;
        check("halt_persist",   {31'b0, halt},     32'd1);
        check("halt_no_redir",  {31'b0, redirect}, 32'd0);

        // Reset recovers from halt.
        rst = 1'b1;
        #2;
        check("rst2_halt",       {31'b0, halt},       32'd0);
        check("rst2_reset_perm", {31'b0, reset_perm}, 32'd1);
        read_csr(2'd0, "rst2_mepc", 32'h0);
        step();
        rst = 1'b0;

        // Fault in the reset handler without mret halts.
        code_f = `E_ILLEGAL_INSTR; pc_f = 32'h0004_0004;
        step();
        code_f = `NO_E;
        check("rh_fault_halt", {31'b0, halt}, 32'd1);
        read_csr(2'd0, "rh_mepc_keep", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
